// File: rtl/jtgng_dwnld_pkg.sv
// Shared types and sizing helpers for the ioctl-to-romload download bridge.
package jtgng_dwnld_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_AW       = 19;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_WR_GAP   = 2;
    localparam int DEF_RST_HOLD = 16;

    // Bits needed to hold any value in 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int ENTRY_W = DEF_AW + 8;
    localparam int COUNT_W = cnt_w(DEF_DEPTH);
    localparam int GAP_W   = cnt_w(DEF_WR_GAP - 1);
    localparam int HOLD_W  = cnt_w(DEF_RST_HOLD);

endpackage

// File: rtl/jtgng_dwnld_fifo.sv
// Small synchronous FIFO holding {address, data} entries awaiting a romload write.
// A push into a full FIFO is dropped even if a pop happens in the same clock.
module jtgng_dwnld_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/jtgng_dwnld.sv
// Converts the HPS ioctl byte stream into paced romload writes, tracks
// bad-address / overrun flags and a byte checksum, and holds the game in
// reset while a download is in progress and for a while after it.
//
// state | meaning
// RUN   | game running, no download activity
// LOAD  | HPS transferring bytes, FIFO accepting
// FLUSH | transfer ended, draining remaining FIFO entries
// HOLD  | FIFO drained, counting down before releasing game_rst
module jtgng_dwnld
    import jtgng_dwnld_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WR_GAP   = DEF_WR_GAP,
    parameter int RST_HOLD = DEF_RST_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          ioctl_wait,
    output logic          romload_wr,
    output logic [AW-1:0] romload_addr,
    output logic [7:0]    romload_data,
    output logic          game_rst,
    output logic          downloading,
    output logic          oor,
    output logic          ovf,
    output logic [15:0]   checksum
);
    localparam int EW = AW + 8;
    localparam int CW = cnt_w(DEPTH);
    localparam int GW = cnt_w(WR_GAP - 1);
    localparam int HW = cnt_w(RST_HOLD);

    state_t        r_state, w_state_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [GW-1:0] r_gap;
    logic          r_game_rst;
    logic          r_romload_wr;
    logic [AW-1:0] r_romload_addr;
    logic [7:0]    r_romload_data;
    logic          r_wait;
    logic          r_oor, r_ovf;
    logic [15:0]   r_checksum;

    logic          w_in_range, w_wr_dl, w_push, w_pop, w_enter_load;
    logic          w_full, w_empty;
    logic [EW-1:0] w_dout;
    logic [CW-1:0] w_count;

    assign w_in_range   = ((ioctl_addr >> AW) == 25'd0);
    assign w_wr_dl      = ioctl_wr & ioctl_download;
    assign w_push       = w_wr_dl & w_in_range & ~w_full;
    assign w_pop        = ~w_empty & (r_gap == '0);
    assign w_enter_load = ioctl_download & (r_state != LOAD);

    jtgng_dwnld_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({ioctl_addr[AW-1:0], ioctl_data}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state and hold-counter decode; a raised download always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        if (ioctl_download) begin
            w_state_nxt = LOAD;
        end else begin
            case (r_state)
                LOAD:  w_state_nxt = FLUSH;
                FLUSH: if (w_empty && r_gap == '0) begin
                    w_state_nxt = HOLD;
                    w_hold_nxt  = HW'(RST_HOLD);
                end
                HOLD: begin
                    w_hold_nxt = r_hold - 1'b1;
                    if (r_hold == HW'(1)) w_state_nxt = RUN;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register; game_rst is registered from the next state so it
    // tracks "not RUN" without an extra clock of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HOLD;
            r_hold     <= HW'(RST_HOLD);
            r_game_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_game_rst <= (w_state_nxt != RUN);
        end
    end

    // Write pacing: pop one entry whenever the gap counter has run out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap          <= '0;
            r_romload_wr   <= 1'b0;
            r_romload_addr <= '0;
            r_romload_data <= '0;
            r_wait         <= 1'b0;
        end else begin
            r_romload_wr <= w_pop;
            r_wait       <= (w_count >= CW'(DEPTH - 1));
            if (w_pop) begin
                {r_romload_addr, r_romload_data} <= w_dout;
                r_gap <= GW'(WR_GAP - 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    // Sticky flags and checksum; a new download clears them, but a byte
    // accepted on that same clock still counts toward the fresh checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oor      <= 1'b0;
            r_ovf      <= 1'b0;
            r_checksum <= '0;
        end else begin
            r_oor      <= (r_oor & ~w_enter_load) | (w_wr_dl & ~w_in_range);
            r_ovf      <= (r_ovf & ~w_enter_load) | (w_wr_dl & w_in_range & w_full);
            r_checksum <= (w_enter_load ? 16'd0 : r_checksum)
                        + (w_push ? {8'd0, ioctl_data} : 16'd0);
        end
    end

    assign ioctl_wait   = r_wait;
    assign romload_wr   = r_romload_wr;
    assign romload_addr = r_romload_addr;
    assign romload_data = r_romload_data;
    assign game_rst     = r_game_rst;
    assign downloading  = (r_state == LOAD) || (r_state == FLUSH);
    assign oor          = r_oor;
    assign ovf          = r_ovf;
    assign checksum     = r_checksum;

endmodule

// File: tb/tb_jtgng_dwnld.sv
// Directed bench for jtgng_dwnld: stimulus pushes expected romload writes
// (address, data, cycle) into a queue, and a monitor pops and compares on
// every romload_wr strobe.
module tb_jtgng_dwnld;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wait, romload_wr, game_rst, downloading, oor, ovf;
    logic [18:0] romload_addr;
    logic [7:0]  romload_data;
    logic [15:0] checksum;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    jtgng_dwnld dut (
        .clk            (clk),
        .rst            (rst),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .romload_wr     (romload_wr),
        .romload_addr   (romload_addr),
        .romload_data   (romload_data),
        .game_rst       (game_rst),
        .downloading    (downloading),
        .oor            (oor),
        .ovf            (ovf),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every romload strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (romload_wr === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got addr %h data %h cyc %0d, want no write",
                         romload_addr, romload_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (romload_addr === mon_e.a && romload_data === mon_e.d && cyc == mon_e.c)
                    n_pass++;
                else
                    $display("FAIL romload_write: got addr %h data %h cyc %0d, want addr %h data %h cyc %0d",
                             romload_addr, romload_data, cyc, mon_e.a, mon_e.d, mon_e.c);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-clock ioctl_wr; exp_cyc < 0 means the byte must not be written.
    task automatic send(input logic [24:0] a, input logic [7:0] d, input int exp_cyc);
        exp_t e;
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (exp_cyc >= 0) begin
            e.a = a[18:0];
            e.d = d;
            e.c = exp_cyc;
            sb.push_back(e);
        end
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    logic [7:0] wexp;
    logic       seen_flag;
    exp_t       be;

    initial begin
        tick(3);
        chk("rst_game_rst", game_rst, 1);
        chk("rst_downloading", downloading, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_flags", {oor, ovf}, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_romload_addr_data", {romload_addr, romload_data}, 0);

        // Release with no download: 16 clocks of game_rst.
        rst = 1'b0;
        seen_flag = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (downloading) seen_flag = 1'b1;
            if (i == 15) chk("rst_hold_hi", game_rst, 1);
            if (i == 16) chk("rst_hold_lo", game_rst, 0);
        end
        chk("rst_no_downloading", seen_flag, 0);

        // Three paced bytes.
        ioctl_download = 1'b1;
        tick(1);
        chk("load_downloading", downloading, 1);
        chk("load_game_rst", game_rst, 1);
        send(25'h0000000, 8'hA5, cyc + 2); tick(9);
        send(25'h0000001, 8'h5A, cyc + 2); tick(9);
        send(25'h007FFFF, 8'hFF, cyc + 2); tick(3);
        chk("checksum_3bytes", checksum, 16'h01FE);
        ioctl_download = 1'b0;
        tick(1);
        chk("flush_downloading", downloading, 1);
        tick(1);
        chk("hold_downloading", downloading, 0);
        chk("hold_game_rst", game_rst, 1);
        tick(15);
        chk("release_hi", game_rst, 1);
        tick(1);
        chk("release_lo", game_rst, 0);

        // Burst of 8 ignoring ioctl_wait: 7 accepted, 8th overflows.
        ioctl_download = 1'b1;
        tick(2);
        wexp = 8'b1110_0000;
        begin
            int k0;
            k0 = cyc;
            for (int i = 0; i < 8; i++) begin
                ioctl_addr = 25'h100 + 25'(i);
                ioctl_data = 8'h10 + 8'(i);
                ioctl_wr   = 1'b1;
                if (i < 7) begin
                    be.a = 19'h100 + 19'(i);
                    be.d = 8'h10 + 8'(i);
                    be.c = k0 + 2 + 2 * i;
                    sb.push_back(be);
                end
                tick(1);
                chk($sformatf("wait_burst%0d", i), ioctl_wait, wexp[i]);
            end
        end
        ioctl_wr = 1'b0;
        tick(10);
        chk("burst_ovf", ovf, 1);
        chk("burst_oor", oor, 0);
        chk("burst_checksum", checksum, 16'h0085);
        chk("burst_wait_low", ioctl_wait, 0);

        // Out-of-range address, then a new download edge clears state.
        send(25'h0080000, 8'h33, -1);
        tick(3);
        chk("oor_set", oor, 1);
        chk("oor_checksum", checksum, 16'h0085);
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        tick(1);
        chk("reload_clears", {15'd0, oor, ovf}, 0);
        chk("reload_checksum", checksum, 0);

        // Reset mid-download with two bytes still queued.
        send(25'h0000010, 8'h11, cyc + 2);
        send(25'h0000011, 8'h22, -1);
        send(25'h0000012, 8'h33, -1);
        rst = 1'b1;
        tick(1);
        chk("midrst_downloading", downloading, 0);
        chk("midrst_checksum", checksum, 0);
        rst = 1'b0;
        tick(1);
        chk("midrst_load", downloading, 1);
        chk("midrst_game_rst", game_rst, 1);
        send(25'h0012345, 8'h77, cyc + 2);
        tick(4);
        chk("midrst_checksum_after", checksum, 16'h0077);

        // Download re-asserted during HOLD.
        ioctl_download = 1'b0;
        seen_flag = 1'b0;
        tick(1);
        if (!game_rst) seen_flag = 1'b1;
        tick(1);
        chk("hold2_downloading", downloading, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (!game_rst) seen_flag = 1'b1;
        end
        ioctl_download = 1'b1;
        tick(1);
        if (!game_rst) seen_flag = 1'b1;
        chk("hold2_load", downloading, 1);
        chk("hold2_checksum_clear", checksum, 0);
        send(25'h0000020, 8'h42, cyc + 2);
        if (!game_rst) seen_flag = 1'b1;
        tick(3);
        if (!game_rst) seen_flag = 1'b1;
        chk("hold2_checksum", checksum, 16'h0042);
        chk("hold2_game_rst_never_low", seen_flag, 0);
        ioctl_download = 1'b0;
        tick(18);
        chk("final_run", game_rst, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
